// File: rtl/sync_fifo_cntrl_pkg.sv
// Shared definitions for sync_fifo_cntrl.
// - calc_aw   : address width derived from the FIFO depth
// - def_afull : default almost-full threshold (depth-2)
// - cfg_ok    : elaboration-time legality check of depth and thresholds
package sync_fifo_cntrl_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_AEMPTY_THR = 2;

  function automatic int calc_aw(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int def_afull(input int depth);
    return depth - 2;
  endfunction

  // Depth must be a power of two (>= 4) so pointers wrap for free;
  // thresholds must be ordered and reachable.
  function automatic bit cfg_ok(input int depth, input int aempty, input int afull);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (aempty >= 0) && (aempty < afull) && (afull <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_cntrl_fifo_regmem.sv
// fifo_regmem: register-array storage for the FIFO.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low clear of every word
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - combinational read address
//   rdata_o  - combinational read data (mem[raddr_i])
module fifo_regmem #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DEPTH-1:0][DW-1:0] mem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_cntrl.sv
// sync_fifo_cntrl: single-clock first-word-fall-through FIFO with
// occupancy count, full/empty, programmable almost flags, sticky
// overflow/underflow errors and a synchronous flush.
// Ports:
//   clk, rst        - clock (rising) / asynchronous active-low reset
//   flush           - synchronous clear of pointers, count and errors
//   w_inc, w_data   - push request and data
//   r_inc, r_data   - pop request and head-of-FIFO word
//   full, empty     - count == fifo_depth / count == 0
//   almost_full     - count >= afull_thr
//   almost_empty    - count <= aempty_thr
//   count           - occupancy 0..fifo_depth
//   overflow        - sticky: push attempted while full
//   underflow       - sticky: pop attempted while empty
//   clr_err         - clears overflow/underflow (a same-cycle set wins)
module sync_fifo_cntrl
  import sync_fifo_cntrl_pkg::*;
#(
  parameter  int data_width = DEF_DATA_W,
  parameter  int fifo_depth = DEF_DEPTH,
  parameter  int afull_thr  = def_afull(fifo_depth),
  parameter  int aempty_thr = DEF_AEMPTY_THR,
  localparam int add_width  = calc_aw(fifo_depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  w_inc,
  input  logic [data_width-1:0] w_data,
  input  logic                  r_inc,
  output logic [data_width-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [add_width:0]    count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  if (!cfg_ok(fifo_depth, aempty_thr, afull_thr)) begin : g_bad_cfg
    $error("sync_fifo_cntrl: illegal fifo_depth / threshold combination");
  end

  localparam logic [add_width:0]   DEPTH_C  = (add_width+1)'(fifo_depth);
  localparam logic [add_width:0]   AFULL_C  = (add_width+1)'(afull_thr);
  localparam logic [add_width:0]   AEMPTY_C = (add_width+1)'(aempty_thr);
  localparam logic [add_width:0]   CNT_ONE  = (add_width+1)'(1);
  localparam logic [add_width-1:0] PTR_ONE  = add_width'(1);

  logic [add_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [add_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [add_width:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 wclken, rclken;

  // Flags come from registered count only, never from the requests.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // Acceptance looks at this cycle's flags, so a pop cannot make room
  // for a same-cycle push (and vice versa). Flush suppresses both.
  assign wclken = w_inc && !full  && !flush;
  assign rclken = r_inc && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wclken) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rclken) rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({wclken, rclken})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      // Set beats clear when both happen together.
      ovf_d = (w_inc && full)  || (ovf_q && !clr_err);
      udf_d = (r_inc && empty) || (udf_q && !clr_err);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_regmem #(
    .DW    (data_width),
    .DEPTH (fifo_depth),
    .AW    (add_width)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wclken),
    .waddr_i (wr_ptr_q),
    .wdata_i (w_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (r_data)
  );

endmodule

// File: tb/tb_sync_fifo_cntrl.sv
module tb_sync_fifo_cntrl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       w_inc = 1'b0;
  logic       r_inc = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] w_data = '0;
  logic [7:0] r_data;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  sync_fifo_cntrl dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .w_inc        (w_inc),
    .w_data       (w_data),
    .r_inc        (r_inc),
    .r_data       (r_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of words plus two sticky bits.
  logic [7:0] mq[$];
  bit m_ov, m_un;
  bit m_full, m_empty;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      m_full  = (mq.size() == DEPTH);
      m_empty = (mq.size() == 0);
      m_ov = (w_inc && m_full)  || (m_ov && !clr_err);
      m_un = (r_inc && m_empty) || (m_un && !clr_err);
      if (r_inc && !m_empty) void'(mq.pop_front());
      if (w_inc && !m_full)  mq.push_back(w_data);
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst && chk_en) begin
      chk("count",        int'(count),        mq.size());
      chk("empty",        int'(empty),        int'(mq.size() == 0));
      chk("full",         int'(full),         int'(mq.size() == DEPTH));
      chk("almost_full",  int'(almost_full),  int'(mq.size() >= DEPTH - 2));
      chk("almost_empty", int'(almost_empty), int'(mq.size() <= 2));
      chk("overflow",     int'(overflow),     int'(m_ov));
      chk("underflow",    int'(underflow),    int'(m_un));
      if (mq.size() > 0) chk("r_data", int'(r_data), int'(mq[0]));
    end
  end

  task automatic cyc(input bit w, input bit r, input logic [7:0] d,
                     input bit fl = 1'b0, input bit ce = 1'b0);
    w_inc   = w;
    r_inc   = r;
    w_data  = d;
    flush   = fl;
    clr_err = ce;
    @(posedge clk);
    @(negedge clk);
    w_inc = 1'b0; r_inc = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_aempty", int'(almost_empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_afull", int'(almost_full), 0);
    chk("rst_rdata", int'(r_data), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_udf", int'(underflow), 0);
    rst = 1'b1;
    chk_en = 1'b1;

    // Pop on empty sets underflow; then build count=3 and reset mid-traffic.
    cyc(1'b0, 1'b1, 8'h00);
    chk("udf_set", int'(underflow), 1);
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 8'(i));
    chk("pre_rst_count", int'(count), 3);
    #2 rst = 1'b0;
    #1;
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_rdata", int'(r_data), 0);
    chk("midrst_udf", int'(underflow), 0);
    chk("midrst_ovf", int'(overflow), 0);
    #1 rst = 1'b1;
    @(negedge clk);

    // Fill 0x11..0x88, then drain in order.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 8'((i + 1) * 17));
      chk("fill_count", int'(count), i + 1);
      chk("fill_afull", int'(almost_full), int'(i + 1 >= 6));
      chk("fill_full", int'(full), int'(i + 1 == 8));
      chk("fill_aempty", int'(almost_empty), int'(i + 1 <= 2));
    end
    for (int i = 0; i < 8; i++) begin
      chk("drain_rdata", int'(r_data), (i + 1) * 17);
      cyc(1'b0, 1'b1, 8'h00);
    end
    chk("drain_empty", int'(empty), 1);

    // At full: simultaneous push+pop -> only the pop happens.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i));
    chk("refill_full", int'(full), 1);
    cyc(1'b1, 1'b1, 8'hEE);
    chk("fullwr_count", int'(count), 7);
    chk("fullwr_ovf", int'(overflow), 1);
    chk("fullwr_rdata", int'(r_data), 8'h31);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", int'(overflow), 0);

    // At empty: simultaneous push+pop -> only the push happens.
    repeat (7) cyc(1'b0, 1'b1, 8'h00);
    chk("empty_again", int'(empty), 1);
    cyc(1'b1, 1'b1, 8'hA5);
    chk("emptyrd_udf", int'(underflow), 1);
    chk("emptyrd_count", int'(count), 1);
    chk("emptyrd_rdata", int'(r_data), 8'hA5);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_udf", int'(underflow), 0);

    // Wrap-around with push/pop pairs at count=4.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'hB0 + i));
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 8'(8'hC0 + i));
      chk("wrap_count", int'(count), 4);
    end
    chk("wrap_head", int'(r_data), 8'hD0);

    // Flush at count=5 with a concurrent push.
    cyc(1'b1, 1'b0, 8'hE0);
    chk("preflush_count", int'(count), 5);
    cyc(1'b1, 1'b0, 8'hEF, 1'b1);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_ovf", int'(overflow), 0);
    cyc(1'b1, 1'b0, 8'h5A);
    chk("postflush_rdata", int'(r_data), 8'h5A);

    // Randomised traffic with alternating fill/drain bias.
    for (int ph = 0; ph < 10; ph++) begin
      for (int k = 0; k < 200; k++) begin
        int wp;
        wp = (ph % 2 == 0) ? 70 : 30;
        cyc(bit'($urandom_range(99) < wp), bit'($urandom_range(99) < 100 - wp),
            8'($urandom), bit'($urandom_range(199) == 0),
            bit'($urandom_range(19) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
